bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble). One bit is processed per clock.
- Generalises the team's fixed 4-bit combinational converter to any input width and digit count.
- Adds an optional two's-complement (sign-magnitude) mode and valid/ready handshakes on both sides.
- Sits between datapath counters/ALU results and display or UART formatting logic.

Parameters:
- W, 8: binary input width; legal range 2..32.
- DIGITS, 3: number of BCD output digits. Elaboration fails if DIGITS < ceil(W*log10(2)).
- CNT_W, $clog2(W+1): width of the internal bit counter. Derived; not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a request is present.
- in_ready  out  1  converter can accept a request.
- in_bin  in  W  binary operand.
- in_signed  in  1  1 = treat in_bin as two's complement.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer accepts the result.
- out_bcd  out  4*DIGITS  BCD result; digit 0 is in bits [3:0].
- out_neg  out  1  result is negative (signed mode only).

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE; out_valid=0, out_bcd=0, out_neg=0.
  - Internal shift register and counter cleared.
  - in_ready=1 as soon as rst_n is deasserted.
- State machine has three states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). It is combinational from state only and never depends on in_valid.
- IDLE:
  - On in_valid && in_ready at edge E0:
    - mag = (in_signed && in_bin[W-1]) ? -in_bin : in_bin. Computed in W bits and interpreted as unsigned, so -2^(W-1) yields magnitude 2^(W-1).
    - Register the sign into a neg flag.
    - Load bcd_reg=0, bin_reg=mag, cnt=W; go to SHIFT.
- SHIFT, one cycle per bit:
  - For each digit: if digit >= 5, add 3.
  - Then shift {bcd_reg, bin_reg} left by 1 and decrement cnt.
  - When the shift that brings cnt to 0 completes, go to DONE.
  - SHIFT lasts exactly W cycles.
- DONE:
  - out_valid=1, out_bcd=bcd_reg, out_neg=neg flag. These are registered and first valid after edge E0+W.
  - Latency from accept to out_valid is W cycles.
  - out_bcd and out_neg hold stable while out_valid && !out_ready.
  - On out_valid && out_ready: go to IDLE; out_valid falls on the next edge. out_bcd and out_neg keep their last values.
- Throughput: at most one conversion every W+2 cycles, assuming out_ready is held high.
- in_bin and in_signed are sampled only at acceptance. Later changes have no effect on a conversion in progress.
- in_valid while busy: the request is not accepted. The upstream source must hold it.
- Zero input: out_bcd=0, out_neg=0. Negative zero is impossible.
- Unsigned mode: in_bin MSB set means a large positive value; out_neg=0.
- Reset mid-operation: the conversion is abandoned immediately, with no output pulse.
- out_valid and in_ready are never both 1 in the same cycle.

Decomposition:
- Package bcd_pkg:
  - State enum {IDLE, SHIFT, DONE} (2-bit).
  - Function min_digits(w), returning ceil(w*log10 2) via integer math, used for the elaboration check.
  - Constant BCD_ADJ_THRESH=4'd5.
- Sub-module bcd_digit_adjust:
  - Purely combinational: a 4-bit digit in; digit+3 out if >=5, else the digit unchanged.
  - Instantiated DIGITS times with a generate loop.

Test Plan:
- W=8, DIGITS=3, unsigned in_bin=8'd255, out_ready=1: out_valid rises 8 cycles after accept; out_bcd=12'h255; out_neg=0. Then in_bin=0 gives 12'h000.
- W=8, signed in_bin=8'h80: out_bcd=12'h128, out_neg=1. Signed 8'hFF gives 12'h001, out_neg=1. Signed 8'h7F gives 12'h127, out_neg=0.
- W=4, DIGITS=2: sweep 0..15 unsigned; out_bcd equals a decimal reference, e.g. 4'd10 gives 8'h10 and 4'd15 gives 8'h15. in_ready stays low during the 4 SHIFT cycles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_bin=8'd99. out_bcd stays 12'h099 throughout and in_ready stays 0. Raising out_ready gives one handshake, then in_ready=1 on the next cycle.
- Reset mid-op: assert rst_n=0 asynchronously at SHIFT cycle 3 of a conversion of 200. Outputs clear immediately; no out_valid pulse. A new request of 42 afterwards yields 12'h042.
- W=16, DIGITS=5: in_bin=16'd65535 gives 20'h65535 after 16 cycles. Back-to-back requests with in_valid held high are accepted every 18 cycles.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   state_t         - converter state encoding (IDLE, SHIFT, DONE)
//   BCD_ADJ_THRESH  - digit value at or above which +3 is applied before a shift
//   min_digits(w)   - decimal digits needed for a w-bit unsigned value,
//                     ceil(w * log10(2)), evaluated with integer math
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

    // 30103/100000 slightly overestimates log10(2); for w <= 32 no product
    // lands close enough to an integer for that to change the ceiling.
    function automatic int min_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// Combinational add-3 correction for one BCD digit ahead of a left shift.
//   digit : in  4  current BCD digit (0..9)
//   adj   : out 4  digit + 3 when digit >= 5, otherwise digit unchanged
// -----------------------------------------------------------------------------
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    assign adj = (digit >= BCD_ADJ_THRESH) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with optional two's-complement input (sign-magnitude result) and
// valid/ready handshakes on both sides.
//   clk       : in  1         rising-edge clock
//   rst_n     : in  1         asynchronous active-low reset
//   in_valid  : in  1         request present
//   in_ready  : out 1         converter idle and able to accept
//   in_bin    : in  W         binary operand, sampled only at acceptance
//   in_signed : in  1         1 = in_bin is two's complement
//   out_valid : out 1         result available
//   out_ready : in  1         consumer accepts result
//   out_bcd   : out 4*DIGITS  BCD result, digit 0 in [3:0]
//   out_neg   : out 1         result is negative (signed mode only)
// Latency from accept to out_valid is W cycles; one conversion per W+2 cycles.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 3,
    parameter int CNT_W  = $clog2(W + 1)
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_bin,
    input  logic                  in_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_neg
);

    generate
        if (W < 2 || W > 32) begin : g_bad_width
            $error("bin_to_bcd_seq: W must be in 2..32");
        end
        if (DIGITS < min_digits(W)) begin : g_bad_digits
            $error("bin_to_bcd_seq: DIGITS too small for W");
        end
    endgenerate

    state_t                state;
    logic [4*DIGITS-1:0]   bcd_reg;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic [4*DIGITS-1:0]   bcd_next;
    logic [W-1:0]          bin_reg;
    logic [CNT_W-1:0]      cnt;
    logic                  neg;

    logic signed [W-1:0]   bin_s;
    logic [W-1:0]          mag;
    logic                  is_neg;

    // Negation wraps in W bits, so the most negative input maps to 2^(W-1)
    // when read back as unsigned.
    assign bin_s  = $signed(in_bin);
    assign is_neg = in_signed && in_bin[W-1];
    assign mag    = is_neg ? $unsigned(-bin_s) : in_bin;

    assign in_ready = (state == IDLE);

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit (bcd_reg[4*d +: 4]),
            .adj   (bcd_adj[4*d +: 4])
        );
    end

    // Adjusted digits shift left by one, pulling in the next binary MSB.
    assign bcd_next = {bcd_adj[4*DIGITS-2:0], bin_reg[W-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bcd_reg   <= '0;
            bin_reg   <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_neg   <= 1'b0;
        end else begin
            case (state)
                // ---- accept: capture magnitude and sign ----
                IDLE: begin
                    if (in_valid) begin
                        bcd_reg <= '0;
                        bin_reg <= mag;
                        cnt     <= CNT_W'(W);
                        neg     <= is_neg;
                        state   <= SHIFT;
                    end
                end
                // ---- one adjust-and-shift per cycle ----
                SHIFT: begin
                    bcd_reg <= bcd_next;
                    bin_reg <= {bin_reg[W-2:0], 1'b0};
                    cnt     <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_bcd   <= bcd_next;
                        out_neg   <= neg;
                    end
                end
                // ---- hold result until consumer takes it ----
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Directed-vector bench for bin_to_bcd_seq at three widths (8/3, 4/2, 16/5).
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    logic clk;
    logic rst_n;

    // W=8, DIGITS=3
    logic        vld8, rdy8, sgn8, ovld8, ordy8, oneg8;
    logic [7:0]  bin8;
    logic [11:0] obcd8;
    // W=4, DIGITS=2
    logic        vld4, rdy4, sgn4, ovld4, ordy4, oneg4;
    logic [3:0]  bin4;
    logic [7:0]  obcd4;
    // W=16, DIGITS=5
    logic        vld16, rdy16, sgn16, ovld16, ordy16, oneg16;
    logic [15:0] bin16;
    logic [19:0] obcd16;

    int checks;
    int fails;

    bin_to_bcd_seq #(.W(8), .DIGITS(3)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld8), .in_ready(rdy8),
        .in_bin(bin8), .in_signed(sgn8), .out_valid(ovld8),
        .out_ready(ordy8), .out_bcd(obcd8), .out_neg(oneg8)
    );

    bin_to_bcd_seq #(.W(4), .DIGITS(2)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld4), .in_ready(rdy4),
        .in_bin(bin4), .in_signed(sgn4), .out_valid(ovld4),
        .out_ready(ordy4), .out_bcd(obcd4), .out_neg(oneg4)
    );

    bin_to_bcd_seq #(.W(16), .DIGITS(5)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld16), .in_ready(rdy16),
        .in_bin(bin16), .in_signed(sgn16), .out_valid(ovld16),
        .out_ready(ordy16), .out_bcd(obcd16), .out_neg(oneg16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request on the 8-bit DUT and return #1 after the accept edge,
    // with the inputs scrambled so late changes would show up in the result.
    task automatic start8(input string tag, input logic [7:0] bin, input logic sgn);
        int waitc;
        waitc = 0;
        while (!rdy8 && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        chk({tag, "_rdy"}, 32'(rdy8), 32'd1);
        vld8 = 1'b1; bin8 = bin; sgn8 = sgn;
        @(posedge clk); #1;
        vld8 = 1'b0; bin8 = ~bin; sgn8 = ~sgn;
    endtask

    task automatic conv8(input string tag, input logic [7:0] bin, input logic sgn,
                         input logic [11:0] exp_bcd, input logic exp_neg);
        int early;
        start8(tag, bin, sgn);
        early = 0;
        for (int i = 0; i < 8; i++) begin
            if (ovld8 || rdy8) early++;
            @(posedge clk); #1;
        end
        chk({tag, "_early"}, 32'(early), 32'd0);
        chk({tag, "_vld"},   32'(ovld8), 32'd1);
        chk({tag, "_bcd"},   32'(obcd8), 32'(exp_bcd));
        chk({tag, "_neg"},   32'(oneg8), 32'(exp_neg));
        @(posedge clk); #1;
        chk({tag, "_drain"}, {30'd0, ovld8, rdy8}, 32'd1);
    endtask

    task automatic conv4(input string tag, input logic [3:0] bin, input logic [7:0] exp_bcd);
        int early;
        int waitc;
        waitc = 0;
        while (!rdy4 && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        vld4 = 1'b1; bin4 = bin; sgn4 = 1'b0;
        @(posedge clk); #1;
        vld4 = 1'b0; bin4 = ~bin;
        early = 0;
        for (int i = 0; i < 4; i++) begin
            if (ovld4 || rdy4) early++;
            @(posedge clk); #1;
        end
        chk({tag, "_early"}, 32'(early), 32'd0);
        chk({tag, "_bcd"},   {22'd0, ovld4, oneg4, obcd4}, {22'd0, 1'b1, 1'b0, exp_bcd});
        @(posedge clk); #1;
    endtask

    task automatic conv16(input string tag, input logic [15:0] bin, input logic [19:0] exp_bcd);
        int early;
        vld16 = 1'b1; bin16 = bin; sgn16 = 1'b0;
        @(posedge clk); #1;
        vld16 = 1'b0; bin16 = 16'h0;
        early = 0;
        for (int i = 0; i < 16; i++) begin
            if (ovld16 || rdy16) early++;
            @(posedge clk); #1;
        end
        chk({tag, "_early"}, 32'(early), 32'd0);
        chk({tag, "_vld"},   32'(ovld16), 32'd1);
        chk({tag, "_bcd"},   32'(obcd16), 32'(exp_bcd));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int n_acc;
        int acc_cyc [2];
        logic [7:0] ref4;

        checks = 0;
        fails  = 0;
        rst_n = 1'b0;
        vld8 = 0;  bin8 = '0;  sgn8 = 0;  ordy8 = 1;
        vld4 = 0;  bin4 = '0;  sgn4 = 0;  ordy4 = 1;
        vld16 = 0; bin16 = '0; sgn16 = 0; ordy16 = 1;
        acc_cyc[0] = 0; acc_cyc[1] = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ovld", 32'(ovld8), 32'd0);
        chk("rst_bcd",  32'(obcd8), 32'd0);
        chk("rst_neg",  32'(oneg8), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy",  32'(rdy8), 32'd1);
        @(posedge clk); #1;

        // Unsigned and signed directed vectors on the 8-bit converter
        conv8("u255",  8'd255, 1'b0, 12'h255, 1'b0);
        conv8("u0",    8'd0,   1'b0, 12'h000, 1'b0);
        conv8("s80",   8'h80,  1'b1, 12'h128, 1'b1);
        conv8("sFF",   8'hFF,  1'b1, 12'h001, 1'b1);
        conv8("s7F",   8'h7F,  1'b1, 12'h127, 1'b0);
        conv8("u80",   8'h80,  1'b0, 12'h128, 1'b0);
        conv8("sC8",   8'hC8,  1'b1, 12'h056, 1'b1);
        conv8("s0",    8'h00,  1'b1, 12'h000, 1'b0);

        // Backpressure: result must hold while out_ready is low
        ordy8 = 1'b0;
        start8("bp", 8'd99, 1'b0);
        repeat (8) begin
            @(posedge clk); #1;
        end
        chk("bp_vld", 32'(ovld8), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {19'd0, ovld8, obcd8}, {19'd0, 1'b1, 12'h099});
            chk("bp_rdy",  32'(rdy8), 32'd0);
            @(posedge clk); #1;
        end
        ordy8 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {30'd0, ovld8, rdy8}, 32'd1);
        chk("bp_keep",    32'(obcd8), 32'h099);

        // Reset in the middle of a conversion of 200
        conv8("s7Fb", 8'h7F, 1'b1, 12'h127, 1'b0);
        start8("rmid", 8'd200, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_ovld", 32'(ovld8), 32'd0);
        chk("rmid_bcd",  32'(obcd8), 32'd0);
        chk("rmid_rdy",  32'(rdy8),  32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (ovld8) pulses++;
            @(posedge clk); #1;
        end
        chk("rmid_nopulse", 32'(pulses), 32'd0);
        conv8("u42", 8'd42, 1'b0, 12'h042, 1'b0);

        // 4-bit sweep against decimal reference
        for (int i = 0; i < 16; i++) begin
            ref4[7:4] = 4'(i / 10);
            ref4[3:0] = 4'(i % 10);
            conv4($sformatf("w4_%0d", i), 4'(i), ref4);
        end

        // 16-bit full scale, then back-to-back acceptance spacing
        conv16("w16max", 16'hFFFF, 20'h65535);
        vld16 = 1'b1; bin16 = 16'hFFFF; sgn16 = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 60 && n_acc < 2; c++) begin
            if (rdy16) begin
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            if (ovld16) chk("b2b_bcd", 32'(obcd16), 32'h65535);
            @(posedge clk); #1;
        end
        vld16 = 1'b0;
        chk("b2b_count",   32'(n_acc), 32'd2);
        chk("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
